hevc_row_window_builder: RTL and testbench
==========================================

// Module: hevc_row_window_builder
// PURPOSE
//  Upstream feeder for the 8-tap luma sub-pixel FIR stages (A/B/C, approx multiplierless).
//  Accepts a raster stream of 8-bit integer pixels, one row of ROW_W pixels at a time.
//  Emits one flattened 64-bit, 8-sample window per integer position x = 0..ROW_W-1.
//  Row edges are padded by replicating the border pixel. Valid/ready on both sides.
// PARAMETERS
//  ROW_W   16  pixels per row; legal range 8..128
//  TAG_W   8   width of the per-row tag carried to the output (FIR 's'/'so' path)
// PORTS
//  clock       in   1        single clock, all state on posedge
//  reset       in   1        synchronous, active-high
//  in_valid    in   1        in_pixel/in_tag valid
//  in_ready    out  1        block accepts in_pixel this cycle
//  in_pixel    in   8        integer pixel, raster order within the row
//  in_tag      in   TAG_W    row tag; sampled only with pixel 0 of a row
//  out_valid   out  1        out_window/out_x/out_tag/out_sol/out_eol valid
//  out_ready   in   1        downstream (FIR inputPixels) accepts the window
//  out_window  out  64       [8*i+7:8*i] = sample at x-3+i, i=0..7 (tap 0 at [7:0])
//  out_x       out  7        integer position x of this window
//  out_tag     out  TAG_W    tag of the row this window belongs to
//  out_sol     out  1        high with window x=0
//  out_eol     out  1        high with window x=ROW_W-1
// BEHAVIOUR
//  Reset: out_valid=0, out_window=0, out_x=0, out_tag=0, out_sol=0, out_eol=0, state=IDLE,
//   all counters 0. Reset mid-row or mid-flush discards the partial row; the next
//   accepted pixel is treated as pixel 0.
//  Transfer: input on in_valid&&in_ready; output on out_valid&&out_ready.
//  out_stall = out_valid && !out_ready. Output reg and outputs hold while stalled.
//  Shift reg win[0..7], 8 bits each. A shift drops win[0], moves win[i+1] to win[i],
//   and loads the new sample into win[7].
//  FSM:
//   IDLE   in_ready=1. Pixel p0 accepted: win <= {8{p0}}, latch tag, col=1 -> FILL.
//   FILL   in_ready=1. Accept p1..p3 and shift. After p3 (col=4) -> STREAM. No output.
//   STREAM in_ready=!out_stall. Accept pk (k=4..ROW_W-1): shift.
//          Same edge, load output reg with shifted window, x=k-4, out_valid=1.
//          After p(ROW_W-1) -> FLUSH, fcnt=0.
//   FLUSH  in_ready=0. Each cycle with !out_stall: shift win[7] back into itself,
//          emit x=ROW_W-4+fcnt. After fcnt=3 (x=ROW_W-1) -> IDLE.
//  Output reg clear: out_valid cleared when the window is taken with no new load that cycle.
//  Latency: window x is valid the cycle after pixel x+4 is accepted (x<=ROW_W-5).
//  Flush windows follow at one per cycle when unstalled.
//  Throughput: 1 window/cycle in STREAM/FLUSH.
//  Per row: ROW_W windows for ROW_W pixels, plus 4 non-accepting FLUSH cycles.
//  Back-to-back rows: IDLE/FILL accept the next row while the last flush window waits in
//   the output reg. win is independent of the output reg.
//  out_sol = (x==0). out_eol = (x==ROW_W-1). out_tag = tag latched at p0 of the row.
//  Arithmetic: pixels pass unmodified. No rounding, clipping or sign extension here.
//  Counters: col 7b, fcnt 2b, out_x 7b. All are bounded by ROW_W, so no wrap inside a row.
//  in_ready is a function of state and out_stall only, never of in_valid (no comb loop).
// STRUCTURE
//  Shared package hevc_interp_pkg:
//   PIX_W=8, TAPS=8, WIN_W=PIX_W*TAPS=64, half-taps=3/4 constants,
//   typedef enum {IDLE,FILL,STREAM,FLUSH} win_state_t.
//  One sub-module hevc_win_outreg: a single-entry output register.
//   It holds window/x/tag/sol/eol and the valid/ready stall logic.
//  FSM, counters and win shift register stay in this module.
// TESTING
//  1 Ramp row, ROW_W=16, p_k=10*(k+1), out_ready=1:
//    x=0 window bytes [7:0]..[63:56] = 10,10,10,10,20,30,40,50; out_sol=1.
//    x=15 window = 130,140,150,160,160,160,160,160; out_eol=1; 16 windows total.
//  2 Backpressure: hold out_ready=0 for 5 cycles at x=6.
//    out_window/out_x stable throughout; in_ready=0 in STREAM.
//    No window lost or duplicated; resumes in order.
//  3 Back-to-back rows with in_valid always 1, tags 8'hA5 then 8'h3C.
//    Row 2 pixels are accepted during FLUSH stall. Row 2 x=0 carries out_tag=8'h3C.
//    Rows do not mix: row 2 x=0 window = 4 copies of its own p0, then p1..p4.
//  4 Reset pulse (1 cycle) after p9 of a row: out_valid=0 next cycle.
//    Next pixel 77 is treated as p0; its x=0 window starts 77,77,77,77.
//  5 in_valid gaps (1-in-3 duty) during FILL and STREAM.
//    Output sequence is identical to scenario 1, only spaced in time.
//  6 Constant row of 255 with ROW_W=8: all 8 windows = 64'hFFFF_FFFF_FFFF_FFFF.
//    out_x = 0..7 with no gaps when out_ready=1.

Source files
------------

// File: rtl/hevc_interp_pkg.sv
// Shared constants and types for the HEVC luma interpolation front end.
// The sample width, tap count and window geometry live here so every stage agrees on them.
package hevc_interp_pkg;

    localparam int PIX_W   = 8;
    localparam int TAPS    = 8;
    localparam int WIN_W   = PIX_W * TAPS;
    localparam int X_W     = 7;
    // An 8-tap window centred on x spans x-3 .. x+4.
    localparam int HALF_LO = 3;
    localparam int HALF_HI = 4;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        FLUSH
    } win_state_t;

endpackage

// File: rtl/hevc_win_outreg.sv
// Single-entry output register for the row window builder.
// It holds one window with its position, tag and edge flags until downstream takes it.
module hevc_win_outreg
    import hevc_interp_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIN_W-1:0] load_window,
    input  logic [X_W-1:0]   load_x,
    input  logic [TAG_W-1:0] load_tag,
    input  logic             load_sol,
    input  logic             load_eol,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIN_W-1:0] window,
    output logic [X_W-1:0]   x,
    output logic [TAG_W-1:0] tag,
    output logic             sol,
    output logic             eol
);

    // A load replaces the held entry; otherwise a taken entry simply goes invalid.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            window    <= '0;
            x         <= '0;
            tag       <= '0;
            sol       <= 1'b0;
            eol       <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            window    <= load_window;
            x         <= load_x;
            tag       <= load_tag;
            sol       <= load_sol;
            eol       <= load_eol;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/hevc_row_window_builder.sv
// Turns a raster row of pixels into one 8-sample window per integer position,
// replicating the border pixel past both row edges.
module hevc_row_window_builder
    import hevc_interp_pkg::*;
#(
    parameter int ROW_W = 16,
    parameter int TAG_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIN_W-1:0] out_window,
    output logic [X_W-1:0]   out_x,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_sol,
    output logic             out_eol
);

    localparam logic [X_W-1:0] LAST_COL = X_W'(ROW_W - 1);
    localparam logic [X_W-1:0] FILL_END = X_W'(HALF_HI - 1);
    localparam logic [X_W-1:0] FLUSH_X0 = X_W'(ROW_W - HALF_HI);

    win_state_t       state;
    logic [PIX_W-1:0] win     [TAPS];
    logic [PIX_W-1:0] shifted [TAPS];
    logic [PIX_W-1:0] shift_in;
    logic [X_W-1:0]   col;
    logic [1:0]       fcnt;
    logic [TAG_W-1:0] row_tag;

    logic             out_stall;
    logic             in_fire;
    logic             load;
    logic [WIN_W-1:0] load_window;
    logic [X_W-1:0]   load_x;

    assign out_stall = out_valid && !out_ready;
    assign in_fire   = in_valid && in_ready;

    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            FILL:    in_ready = 1'b1;
            STREAM:  in_ready = !out_stall;
            default: in_ready = 1'b0;
        endcase
    end

    // During flush the last pixel is re-inserted, which is the right-edge replication.
    always_comb begin
        shift_in = (state == FLUSH) ? win[TAPS-1] : in_pixel;
        for (int i = 0; i < TAPS - 1; i++) begin
            shifted[i] = win[i+1];
        end
        shifted[TAPS-1] = shift_in;
        load_window = '0;
        for (int i = 0; i < TAPS; i++) begin
            load_window[PIX_W*i +: PIX_W] = shifted[i];
        end
    end

    assign load   = (state == STREAM && in_fire) || (state == FLUSH && !out_stall);
    assign load_x = (state == FLUSH) ? FLUSH_X0 + X_W'(fcnt) : col - X_W'(HALF_HI);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            col     <= '0;
            fcnt    <= '0;
            row_tag <= '0;
            for (int i = 0; i < TAPS; i++) begin
                win[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        // Filling with p0 supplies the left-edge replication for free.
                        for (int i = 0; i < TAPS; i++) begin
                            win[i] <= in_pixel;
                        end
                        row_tag <= in_tag;
                        col     <= X_W'(1);
                        state   <= FILL;
                    end
                end
                FILL: begin
                    if (in_fire) begin
                        win <= shifted;
                        col <= col + X_W'(1);
                        if (col == FILL_END) begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (in_fire) begin
                        win <= shifted;
                        if (col == LAST_COL) begin
                            col   <= '0;
                            fcnt  <= '0;
                            state <= FLUSH;
                        end else begin
                            col <= col + X_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (!out_stall) begin
                        win  <= shifted;
                        fcnt <= fcnt + 2'd1;
                        if (fcnt == 2'(HALF_LO)) begin
                            fcnt  <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    hevc_win_outreg #(
        .TAG_W (TAG_W)
    ) u_outreg (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .load_window (load_window),
        .load_x      (load_x),
        .load_tag    (row_tag),
        .load_sol    (load_x == '0),
        .load_eol    (load_x == LAST_COL),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .window      (out_window),
        .x           (out_x),
        .tag         (out_tag),
        .sol         (out_sol),
        .eol         (out_eol)
    );

endmodule

// File: tb/tb_hevc_row_window_builder.sv
// Self-checking bench for hevc_row_window_builder: rows of 16 on one instance, rows of 8 on another.
// Expected windows come from clamping x-3+i into the row, independent of how the design shifts.
module tb_hevc_row_window_builder;

    typedef struct packed {
        logic [63:0] win;
        logic [6:0]  x;
        logic [7:0]  tag;
        logic        sol;
        logic        eol;
    } obs_t;

    logic        clock;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, out_sol, out_eol;
    logic [7:0]  in_pixel, in_tag, out_tag;
    logic [63:0] out_window;
    logic [6:0]  out_x;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sol, b_out_eol;
    logic [7:0]  b_in_pixel, b_in_tag, b_out_tag;
    logic [63:0] b_out_window;
    logic [6:0]  b_out_x;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ready_mode = 0;
    int   row_pix[$];
    int   acc_cyc[$];
    obs_t exp_q[$];
    obs_t got_q[$];
    int   got_cyc[$];
    obs_t gotb_q[$];
    int   gotb_cyc[$];

    hevc_row_window_builder #(.ROW_W(16), .TAG_W(8)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
        .out_x(out_x), .out_tag(out_tag), .out_sol(out_sol), .out_eol(out_eol)
    );

    hevc_row_window_builder #(.ROW_W(8), .TAG_W(8)) dut8 (
        .clock(clock), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pixel(b_in_pixel), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_window(b_out_window),
        .out_x(b_out_x), .out_tag(b_out_tag), .out_sol(b_out_sol), .out_eol(b_out_eol)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #1;
        if (ready_mode == 0) out_ready = 1'b1;
        else if (ready_mode == 1) out_ready = ($urandom_range(0, 9) < 7);
    end

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            got_q.push_back(obs_t'({out_window, out_x, out_tag, out_sol, out_eol}));
            got_cyc.push_back(cyc);
        end
        if (!reset && b_out_valid && b_out_ready) begin
            gotb_q.push_back(obs_t'({b_out_window, b_out_x, b_out_tag, b_out_sol, b_out_eol}));
            gotb_cyc.push_back(cyc);
        end
    end

    // Reference: window x, tap i is the row pixel at x-3+i clamped into 0..w-1.
    task automatic model_row(input int base, input int w, input logic [7:0] tag);
        obs_t        o;
        logic [63:0] wv;
        int          idx;
        for (int x = 0; x < w; x++) begin
            for (int i = 0; i < 8; i++) begin
                idx = x - 3 + i;
                if (idx < 0) idx = 0;
                if (idx > w - 1) idx = w - 1;
                wv[8*i +: 8] = 8'(row_pix[base + idx]);
            end
            o.win = wv;
            o.x   = 7'(x);
            o.tag = tag;
            o.sol = (x == 0);
            o.eol = (x == w - 1);
            exp_q.push_back(o);
        end
    endtask

    task automatic feed(input int base, input int n, input logic [7:0] tag, input bit gaps);
        int t;
        bit done;
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat (2) begin @(posedge clock); #1; end
            end
            in_valid = 1'b1;
            in_pixel = 8'(row_pix[base + k]);
            in_tag   = (k == 0) ? tag : 8'($urandom);
            t = 0;
            done = 0;
            while (!done) begin
                @(negedge clock);
                if (in_ready) begin
                    done = 1;
                    acc_cyc.push_back(cyc);
                end
                @(posedge clock); #1;
                t++;
                if (!done && t > 300) begin
                    n_cmp++; n_fail++;
                    $display("[TB] FAIL accept_timeout: pixel %0d not accepted, required accept within 300 cycles", k);
                    done = 1;
                end
            end
        end
    endtask

    task automatic wait_outputs(input int n);
        int t;
        t = 0;
        while (got_q.size() < n && t < 3000) begin @(posedge clock); #1; t++; end
        repeat (6) begin @(posedge clock); #1; end
        n_cmp++;
        if (got_q.size() !== n) begin
            n_fail++;
            $display("[TB] FAIL window_count: got %0d windows, required %0d", got_q.size(), n);
        end
    endtask

    task automatic clear_queues();
        row_pix.delete(); exp_q.delete(); got_q.delete(); got_cyc.delete(); acc_cyc.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_pixel = '0; in_tag = '0;
        b_in_valid = 1'b0; b_in_pixel = '0; b_in_tag = '0; b_out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1; reset = 1'b0;
        @(negedge clock);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_window !== 64'd0) begin n_fail++; $display("[TB] FAIL rst_window: got %h want 0", out_window); end
        n_cmp++; if (out_x !== 7'd0) begin n_fail++; $display("[TB] FAIL rst_x: got %0d want 0", out_x); end
        n_cmp++; if ({out_tag, out_sol, out_eol} !== 10'd0) begin n_fail++; $display("[TB] FAIL rst_tag_flags: got %h want 0", {out_tag, out_sol, out_eol}); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (b_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_b_valid: got %b want 0", b_out_valid); end
        @(posedge clock); #1;
    endtask

    task automatic test_ramp();
        clear_queues();
        ready_mode = 0;
        for (int k = 0; k < 16; k++) row_pix.push_back(10 * (k + 1));
        model_row(0, 16, 8'h11);
        feed(0, 16, 8'h11, 0);
        in_valid = 1'b0;
        wait_outputs(16);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL ramp_win[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
            end
        end
        if (got_q.size() == 16 && acc_cyc.size() == 16) begin
            n_cmp++; if (got_q[0].win !== 64'h32281E140A0A0A0A || got_q[0].sol !== 1'b1) begin n_fail++; $display("[TB] FAIL ramp_x0: got %h sol=%b want 32281e140a0a0a0a sol=1", got_q[0].win, got_q[0].sol); end
            n_cmp++; if (got_q[15].win !== 64'hA0A0A0A0A0968C82 || got_q[15].eol !== 1'b1) begin n_fail++; $display("[TB] FAIL ramp_x15: got %h eol=%b want a0a0a0a0a0968c82 eol=1", got_q[15].win, got_q[15].eol); end
            n_cmp++; if (got_cyc[0] !== acc_cyc[4] + 1) begin n_fail++; $display("[TB] FAIL ramp_latency: x0 at cycle %0d, required %0d", got_cyc[0], acc_cyc[4] + 1); end
            for (int x = 1; x < 16; x++) begin
                n_cmp++;
                if (got_cyc[x] !== got_cyc[x-1] + 1) begin n_fail++; $display("[TB] FAIL ramp_gap[%0d]: at cycle %0d, required %0d", x, got_cyc[x], got_cyc[x-1] + 1); end
            end
        end
    endtask

    task automatic test_backpressure();
        int          t;
        logic [63:0] hw;
        logic [6:0]  hx;
        clear_queues();
        ready_mode = 2; out_ready = 1'b1;
        for (int k = 0; k < 16; k++) row_pix.push_back($urandom_range(0, 255));
        model_row(0, 16, 8'h42);
        fork
            feed(0, 16, 8'h42, 0);
            begin
                t = 0;
                while (!(out_valid === 1'b1 && out_x == 7'd6) && t < 400) begin @(posedge clock); #1; t++; end
                if (t >= 400) begin
                    n_cmp++; n_fail++;
                    $display("[TB] FAIL bp_wait: window x=6 never appeared, required within 400 cycles");
                end else begin
                    out_ready = 1'b0;
                    hw = out_window; hx = out_x;
                    repeat (5) begin
                        @(negedge clock);
                        n_cmp++; if (out_window !== hw || out_x !== hx || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_hold: got x=%0d %h v=%b want x=%0d %h v=1", out_x, out_window, out_valid, hx, hw); end
                        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready: got %b want 0", in_ready); end
                    end
                    @(posedge clock); #1;
                end
                out_ready = 1'b1;
            end
        join
        in_valid = 1'b0;
        wait_outputs(16);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL bp_win[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
            end
        end
        ready_mode = 0;
    endtask

    task automatic test_back_to_back();
        int          t;
        logic [63:0] w2;
        clear_queues();
        ready_mode = 2; out_ready = 1'b1;
        for (int k = 0; k < 32; k++) row_pix.push_back($urandom_range(0, 255));
        model_row(0, 16, 8'hA5);
        model_row(16, 16, 8'h3C);
        fork
            begin
                feed(0, 16, 8'hA5, 0);
                feed(16, 16, 8'h3C, 0);
            end
            begin
                t = 0;
                while (!(out_valid === 1'b1 && out_x == 7'd15) && t < 400) begin @(posedge clock); #1; t++; end
                if (t >= 400) begin
                    n_cmp++; n_fail++;
                    $display("[TB] FAIL b2b_wait: row 1 window x=15 never appeared, required within 400 cycles");
                end else begin
                    out_ready = 1'b0;
                    repeat (3) begin
                        @(negedge clock);
                        n_cmp++; if (in_ready !== 1'b1 || out_x !== 7'd15) begin n_fail++; $display("[TB] FAIL b2b_accept_stalled: in_ready=%b x=%0d want in_ready=1 x=15", in_ready, out_x); end
                    end
                    @(posedge clock); #1;
                end
                out_ready = 1'b1;
            end
        join
        in_valid = 1'b0;
        wait_outputs(32);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL b2b_win[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
            end
        end
        if (got_q.size() > 16) begin
            w2 = {8'(row_pix[20]), 8'(row_pix[19]), 8'(row_pix[18]), 8'(row_pix[17]),
                  {4{8'(row_pix[16])}}};
            n_cmp++; if (got_q[16].tag !== 8'h3C || got_q[16].win !== w2) begin n_fail++; $display("[TB] FAIL b2b_row2_x0: got tag=%h %h want tag=3c %h", got_q[16].tag, got_q[16].win, w2); end
        end
        ready_mode = 0;
    endtask

    task automatic test_reset_midrow();
        clear_queues();
        ready_mode = 0;
        for (int k = 0; k < 16; k++) row_pix.push_back($urandom_range(0, 255));
        feed(0, 10, 8'h99, 0);
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        n_cmp++; if (out_valid !== 1'b0 || out_x !== 7'd0) begin n_fail++; $display("[TB] FAIL midrst_valid: got v=%b x=%0d want v=0 x=0", out_valid, out_x); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_in_ready: got %b want 1", in_ready); end
        @(posedge clock); #1;
        clear_queues();
        row_pix.push_back(77);
        for (int k = 1; k < 16; k++) row_pix.push_back($urandom_range(0, 255));
        model_row(0, 16, 8'h5E);
        feed(0, 16, 8'h5E, 0);
        in_valid = 1'b0;
        wait_outputs(16);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL midrst_win[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
            end
        end
        if (got_q.size() > 0) begin
            n_cmp++; if (got_q[0].win[31:0] !== 32'h4D4D4D4D) begin n_fail++; $display("[TB] FAIL midrst_x0_left: got %h want 4d4d4d4d", got_q[0].win[31:0]); end
        end
    endtask

    task automatic test_gaps();
        clear_queues();
        ready_mode = 0;
        for (int k = 0; k < 16; k++) row_pix.push_back(10 * (k + 1));
        model_row(0, 16, 8'h77);
        feed(0, 16, 8'h77, 1);
        in_valid = 1'b0;
        wait_outputs(16);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL gaps_win[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
            end
        end
    endtask

    task automatic test_const_row8();
        int t;
        bit done;
        gotb_q.delete(); gotb_cyc.delete();
        b_out_ready = 1'b1;
        b_in_valid = 1'b1; b_in_pixel = 8'hFF; b_in_tag = 8'h5A;
        for (int k = 0; k < 8; k++) begin
            t = 0; done = 0;
            while (!done) begin
                @(negedge clock);
                if (b_in_ready) done = 1;
                @(posedge clock); #1;
                t++;
                if (!done && t > 100) begin
                    n_cmp++; n_fail++;
                    $display("[TB] FAIL row8_accept_timeout: pixel %0d not accepted within 100 cycles", k);
                    done = 1;
                end
            end
        end
        b_in_valid = 1'b0;
        t = 0;
        while (gotb_q.size() < 8 && t < 200) begin @(posedge clock); #1; t++; end
        repeat (4) begin @(posedge clock); #1; end
        n_cmp++; if (gotb_q.size() !== 8) begin n_fail++; $display("[TB] FAIL row8_count: got %0d want 8", gotb_q.size()); end
        for (int i = 0; i < 8 && i < gotb_q.size(); i++) begin
            n_cmp++;
            if (gotb_q[i] !== obs_t'({64'hFFFF_FFFF_FFFF_FFFF, 7'(i), 8'h5A, 1'(i == 0), 1'(i == 7)})) begin
                n_fail++;
                $display("[TB] FAIL row8_win[%0d]: got x=%0d %h sol=%b eol=%b want x=%0d all-ones", i, gotb_q[i].x, gotb_q[i].win, gotb_q[i].sol, gotb_q[i].eol, i);
            end
            if (i > 0) begin
                n_cmp++;
                if (gotb_cyc[i] !== gotb_cyc[i-1] + 1) begin n_fail++; $display("[TB] FAIL row8_gap[%0d]: at cycle %0d, required %0d", i, gotb_cyc[i], gotb_cyc[i-1] + 1); end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] tg [2];
        bit         gp [2];
        for (int r = 0; r < 3; r++) begin
            clear_queues();
            ready_mode = 1;
            for (int k = 0; k < 32; k++) row_pix.push_back($urandom_range(0, 255));
            for (int j = 0; j < 2; j++) begin
                tg[j] = 8'($urandom);
                gp[j] = 1'($urandom_range(0, 1));
                model_row(16 * j, 16, tg[j]);
            end
            feed(0, 16, tg[0], gp[0]);
            feed(16, 16, tg[1], gp[1]);
            in_valid = 1'b0;
            wait_outputs(32);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("[TB] FAIL rand%0d_win[%0d]: got %h want %h", r, i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
                end
            end
        end
        ready_mode = 0;
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b1;
        test_reset();
        test_ramp();
        test_backpressure();
        test_back_to_back();
        test_reset_midrow();
        test_gaps();
        test_const_row8();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
